pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Combines the ID-stage hazard stall, the taken branch/jump redirect, the instruction-memory and data-memory busy signals, and halt into per-stage pipeline-register enables and bubble/flush controls.
- Tracks wrong-path fetches that are still in flight on imem, and the halted state.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_stall_ctrl_pkg.sv | 41 ++++
 rtl/pipe_stall_ctrl_if.sv | 34 +++
 rtl/pipe_stall_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DISCARD = 2'b01,
    ST_HALTED  = 2'b10
  } state_e;

  // Instruction word the pipeline registers load when told to bubble/flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
    logic memwb_bubble;
    logic halted;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_bubble: 1'b0,
    exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0, halted: 1'b0};

  localparam stage_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_bubble: 1'b1,
    exmem_en: 1'b0, memwb_en: 1'b0, memwb_bubble: 1'b1, halted: 1'b0};

  localparam stage_ctrl_t CTRL_RETIRE_HALT = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_bubble: 1'b0,
    exmem_en: 1'b0, memwb_en: 1'b1, memwb_bubble: 1'b0, halted: 1'b0};

  localparam stage_ctrl_t CTRL_HALTED = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_bubble: 1'b0,
    exmem_en: 1'b0, memwb_en: 1'b0, memwb_bubble: 1'b0, halted: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request inputs, stage controls and perf counters of the stall sequencer.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_stall_ID;
  logic             branchJumpDTaken_ID;
  logic             imem_stall;
  logic             imem_done;
  logic             dmem_stall;
  logic             halt_WB;
  logic             PC_en;
  logic             IFID_en;
  logic             IFID_flush;
  logic             IDEX_en;
  logic             IDEX_bubble;
  logic             EXMEM_en;
  logic             MEMWB_en;
  logic             MEMWB_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard_stall_ID, branchJumpDTaken_ID, imem_stall, imem_done, dmem_stall, halt_WB,
    input  PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en,
    input  MEMWB_bubble, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard_stall_ID, branchJumpDTaken_ID, imem_stall, imem_done, dmem_stall, halt_WB,
    output PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en,
    output MEMWB_bubble, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: turns hazard, redirect, memory-busy and halt requests
// into per-stage enables, bubbles and flushes for the 5-stage pipeline.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  stage_ctrl_t ctrl;
  logic        stall_inc;
  logic        flush_inc;
  logic        fetch_pending;

  // A completing access wins over a simultaneous busy indication.
  assign fetch_pending = bus.imem_stall && !bus.imem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = CTRL_ADVANCE;
    state_d = state_q;
    if (rst) begin
      ctrl    = CTRL_RESET;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_HALTED: ctrl = CTRL_HALTED;
        ST_RUN, ST_DISCARD: begin
          if (bus.halt_WB) begin
            ctrl    = CTRL_RETIRE_HALT;
            state_d = ST_HALTED;
          end else if (state_q == ST_DISCARD) begin
            // IF/ID keeps loading NOPs until the wrong-path fetch returns;
            // the redirect target is already sitting in PC.
            ctrl.pc_en      = bus.imem_done;
            ctrl.ifid_flush = 1'b1;
            if (bus.dmem_stall) begin
              ctrl.idex_en      = 1'b0;
              ctrl.exmem_en     = 1'b0;
              ctrl.memwb_bubble = 1'b1;
            end else if (bus.hazard_stall_ID) begin
              ctrl.idex_bubble = 1'b1;
            end
            if (bus.imem_done) begin
              state_d = ST_RUN;
            end
          end else if (bus.dmem_stall) begin
            ctrl.pc_en        = 1'b0;
            ctrl.ifid_en      = 1'b0;
            ctrl.idex_en      = 1'b0;
            ctrl.exmem_en     = 1'b0;
            ctrl.memwb_bubble = 1'b1;
          end else if (bus.branchJumpDTaken_ID) begin
            ctrl.ifid_flush = 1'b1;
            if (fetch_pending) begin
              state_d = ST_DISCARD;
            end
          end else if (bus.hazard_stall_ID) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_bubble = 1'b1;
          end else if (fetch_pending) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
          end
        end
        default: begin
          ctrl    = CTRL_RESET;
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign stall_inc = !rst && (state_q != ST_HALTED) && !ctrl.pc_en;
  assign flush_inc = !rst && (state_q != ST_HALTED) && ctrl.ifid_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

  assign bus.PC_en        = ctrl.pc_en;
  assign bus.IFID_en      = ctrl.ifid_en;
  assign bus.IFID_flush   = ctrl.ifid_flush;
  assign bus.IDEX_en      = ctrl.idex_en;
  assign bus.IDEX_bubble  = ctrl.idex_bubble;
  assign bus.EXMEM_en     = ctrl.exmem_en;
  assign bus.MEMWB_en     = ctrl.memwb_en;
  assign bus.MEMWB_bubble = ctrl.memwb_bubble;
  assign bus.halted       = ctrl.halted;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed test-plan sequences plus randomized traffic, checked every cycle
// against a behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_RUN = 0;
  localparam int M_DISC = 1;
  localparam int M_HALT = 2;

  typedef struct packed {
    logic pc, ifid, ifid_fl, idex, idex_bub, exmem, memwb, memwb_bub, hlt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  bit   cmp_en = 1'b0;

  int m_mode = M_RUN;
  int m_stall = 0;
  int m_flush = 0;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // What each stage must do, derived from who is asking for what this cycle.
  function automatic exp_t model_outs(int mode, logic r, logic hz, logic br, logic ims,
                                      logic imd, logic dms, logic hlt);
    exp_t o;
    o = '{pc: 1, ifid: 1, ifid_fl: 0, idex: 1, idex_bub: 0, exmem: 1, memwb: 1,
          memwb_bub: 0, hlt: 0};
    if (r) begin
      o = '{pc: 0, ifid: 0, ifid_fl: 1, idex: 0, idex_bub: 1, exmem: 0, memwb: 0,
            memwb_bub: 1, hlt: 0};
    end else if (mode == M_HALT) begin
      o = '{pc: 0, ifid: 0, ifid_fl: 0, idex: 0, idex_bub: 0, exmem: 0, memwb: 0,
            memwb_bub: 0, hlt: 1};
    end else if (hlt) begin
      o = '{pc: 0, ifid: 0, ifid_fl: 0, idex: 0, idex_bub: 0, exmem: 0, memwb: 1,
            memwb_bub: 0, hlt: 0};
    end else if (mode == M_DISC) begin
      o.ifid_fl = 1;
      o.pc = imd;
      if (dms) begin
        o.idex = 0; o.exmem = 0; o.memwb_bub = 1;
      end else if (hz) begin
        o.idex_bub = 1;
      end
    end else if (dms) begin
      o.pc = 0; o.ifid = 0; o.idex = 0; o.exmem = 0; o.memwb_bub = 1;
    end else if (br) begin
      o.ifid_fl = 1;
    end else if (hz) begin
      o.pc = 0; o.ifid = 0; o.idex_bub = 1;
    end else if (ims && !imd) begin
      o.pc = 0; o.ifid_fl = 1;
    end
    return o;
  endfunction

  function automatic exp_t cur_exp();
    return model_outs(m_mode, rst, bus.hazard_stall_ID, bus.branchJumpDTaken_ID,
                      bus.imem_stall, bus.imem_done, bus.dmem_stall, bus.halt_WB);
  endfunction

  // Model state advance.
  always @(posedge clk) begin
    exp_t o;
    o = cur_exp();
    cycle++;
    if (rst) begin
      m_mode = M_RUN; m_stall = 0; m_flush = 0;
    end else if (m_mode != M_HALT) begin
      if (!o.pc && m_stall < CNT_MAX) m_stall++;
      if (o.ifid_fl && m_flush < CNT_MAX) m_flush++;
      if (bus.halt_WB) m_mode = M_HALT;
      else if (m_mode == M_DISC) m_mode = bus.imem_done ? M_RUN : M_DISC;
      else if (!bus.dmem_stall && bus.branchJumpDTaken_ID && bus.imem_stall && !bus.imem_done)
        m_mode = M_DISC;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_t e;
      exp_t a;
      e = cur_exp();
      a = '{pc: bus.PC_en, ifid: bus.IFID_en, ifid_fl: bus.IFID_flush, idex: bus.IDEX_en,
            idex_bub: bus.IDEX_bubble, exmem: bus.EXMEM_en, memwb: bus.MEMWB_en,
            memwb_bub: bus.MEMWB_bubble, hlt: bus.halted};
      $display("cyc=%0d rst=%b hz=%b br=%b ims=%b imd=%b dms=%b hlt=%b -> ctl=%b st=%0d fl=%0d",
               cycle, rst, bus.hazard_stall_ID, bus.branchJumpDTaken_ID, bus.imem_stall,
               bus.imem_done, bus.dmem_stall, bus.halt_WB, a, bus.stall_cnt, bus.flush_cnt);
      chk("model_ctrl", 32'(a), 32'(e));
      chk("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      chk("model_flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
    end
  end

  task automatic cyc(input logic r, input logic hz, input logic br, input logic ims,
                     input logic imd, input logic dms, input logic hlt);
    @(posedge clk);
    #1;
    rst = r;
    bus.hazard_stall_ID = hz;
    bus.branchJumpDTaken_ID = br;
    bus.imem_stall = ims;
    bus.imem_done = imd;
    bus.dmem_stall = dms;
    bus.halt_WB = hlt;
    @(negedge clk);
  endtask

  initial begin
    bus.hazard_stall_ID = 1; bus.branchJumpDTaken_ID = 1; bus.imem_stall = 1;
    bus.imem_done = 1; bus.dmem_stall = 1; bus.halt_WB = 1;

    // Reset with every request high
    cyc(1, 1, 1, 1, 1, 1, 1);
    cmp_en = 1'b1;
    cyc(1, 1, 1, 1, 1, 1, 1);
    chk("rst_pc_en", 32'(bus.PC_en), 0);
    chk("rst_ifid_en", 32'(bus.IFID_en), 0);
    chk("rst_ifid_flush", 32'(bus.IFID_flush), 1);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idle_pc_en", 32'(bus.PC_en), 1);
    chk("idle_memwb_en", 32'(bus.MEMWB_en), 1);
    chk("idle_ifid_flush", 32'(bus.IFID_flush), 0);

    // Hazard stall, two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("hz_pc_en", 32'(bus.PC_en), 0);
      chk("hz_ifid_en", 32'(bus.IFID_en), 0);
      chk("hz_idex_bubble", 32'(bus.IDEX_bubble), 1);
      chk("hz_exmem_en", 32'(bus.EXMEM_en), 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hz_stall_cnt", 32'(bus.stall_cnt), 2);

    // dmem stall holds a taken branch
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 1, 0);
      chk("dm_pc_en", 32'(bus.PC_en), 0);
      chk("dm_memwb_bubble", 32'(bus.MEMWB_bubble), 1);
      chk("dm_ifid_en", 32'(bus.IFID_en), 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("dm_br_flush", 32'(bus.IFID_flush), 1);
    chk("dm_br_pc_en", 32'(bus.PC_en), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dm_flush_cnt", 32'(bus.flush_cnt), 1);
    chk("dm_stall_cnt", 32'(bus.stall_cnt), 5);

    // Wrong-path discard
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("wp_br_pc_en", 32'(bus.PC_en), 1);
    chk("wp_br_flush", 32'(bus.IFID_flush), 1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("wp_wait_flush", 32'(bus.IFID_flush), 1);
      chk("wp_wait_pc_en", 32'(bus.PC_en), 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wp_done_pc_en", 32'(bus.PC_en), 1);
    chk("wp_done_flush", 32'(bus.IFID_flush), 1);
    chk("wp_flush_cnt", 32'(bus.flush_cnt), 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wp_run_flush", 32'(bus.IFID_flush), 0);
    chk("wp_run_flush_cnt", 32'(bus.flush_cnt), 5);

    // Halt
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("hl_memwb_en", 32'(bus.MEMWB_en), 1);
    chk("hl_pc_en", 32'(bus.PC_en), 0);
    chk("hl_halted_pre", 32'(bus.halted), 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1, 1, 0, 0, 0);
      chk("hl_halted", 32'(bus.halted), 1);
      chk("hl_pc_en_frozen", 32'(bus.PC_en), 0);
      chk("hl_memwb_en_frozen", 32'(bus.MEMWB_en), 0);
      chk("hl_stall_cnt", 32'(bus.stall_cnt), 8);
      chk("hl_flush_cnt", 32'(bus.flush_cnt), 5);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hl_exit_halted", 32'(bus.halted), 0);
    chk("hl_exit_pc_en", 32'(bus.PC_en), 1);

    // Saturation
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX - 1; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sat_pre", 32'(bus.stall_cnt), 32'(CNT_MAX - 1));
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("sat_max", 32'(bus.stall_cnt), 32'(CNT_MAX));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sat_hold", 32'(bus.stall_cnt), 32'(CNT_MAX));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = (m_mode == M_HALT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      cyc(r, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
